cl_axi_mon_trig: RTL and testbench

Passive AXI4 monitor that watches one `axi_bus_t` interface and produces debug trigger and status signals for the CL integrated logic analyzer. It tracks write and read bursts that are still outstanding, and runs per-direction watchdogs. It also performs lightweight protocol checks. Its outputs drive the ILA's spare trigger probes (probe40..probe43) and status probes, so a capture can fire on hangs or protocol violations. One instance is placed per monitored bus (DMA PCIS, DDR A).

---
 rtl/cl_axi_mon_pkg.sv | 33 +++
 rtl/cl_axi_mon_len_fifo.sv | 39 +++
 rtl/cl_axi_mon_trig.sv | 194 +++++++++++++++++++
 tb/tb_cl_axi_mon_trig.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cl_axi_mon_pkg.sv
// cl_axi_mon_pkg: shared types and constants for the AXI monitor/trigger block.
package cl_axi_mon_pkg;

   localparam int MON_IDLE_W = 21;
   localparam int MON_LEN_W  = 8;

   typedef enum logic [3:0] {
      NONE        = 4'd0,
      B_NO_OUTST  = 4'd1,
      R_NO_OUTST  = 4'd2,
      WLAST_EARLY = 4'd3,
      WLAST_LATE  = 4'd4,
      LEN_OVF     = 4'd5
   } mon_err_e;

   // Only the handshake and burst-framing fields the monitor observes.
   typedef struct packed {
      logic                 awvalid;
      logic                 awready;
      logic [MON_LEN_W-1:0] awlen;
      logic                 wvalid;
      logic                 wready;
      logic                 wlast;
      logic                 bvalid;
      logic                 bready;
      logic                 arvalid;
      logic                 arready;
      logic                 rvalid;
      logic                 rready;
      logic                 rlast;
   } axi_bus_t;

endpackage

// File: rtl/cl_axi_mon_len_fifo.sv
// cl_axi_mon_len_fifo: small synchronous FIFO holding awlen values of bursts awaiting W data.
module cl_axi_mon_len_fifo #(
   parameter int DEPTH = 16,
   parameter int W     = 8
) (
   input  logic         aclk,
   input  logic         arst,
   input  logic         push,
   input  logic         pop,
   input  logic [W-1:0] din,
   output logic [W-1:0] head,
   output logic         full,
   output logic         empty
);
   localparam int PW = $clog2(DEPTH);
   localparam logic [PW:0] PTR_ONE = (PW+1)'(1);

   logic [W-1:0] mem [DEPTH];
   logic [PW:0]  wr_ptr, rd_ptr;

   always_ff @(posedge aclk or posedge arst) begin
      if (arst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push && !full) wr_ptr <= wr_ptr + PTR_ONE;
         if (pop && !empty) rd_ptr <= rd_ptr + PTR_ONE;
      end
   end

   always_ff @(posedge aclk) begin
      if (push && !full) mem[wr_ptr[PW-1:0]] <= din;
   end

   assign head  = mem[rd_ptr[PW-1:0]];
   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);

endmodule

// File: rtl/cl_axi_mon_trig.sv
// cl_axi_mon_trig: passive AXI4 monitor producing ILA trigger and status probes.
// Define CL_AXI_MON_PROTO_CHK_EN to compile in the awlen FIFO, W beat check and error codes.
module cl_axi_mon_trig
   import cl_axi_mon_pkg::*;
#(
   parameter int CNT_W          = 8,
   parameter int TIMEOUT_CYCLES = 4096,
   parameter int LEN_FIFO_DEPTH = 16
) (
   input  logic             aclk,
   input  logic             arst,
   input  axi_bus_t         mon_bus,
   input  logic             mon_clr,
   output logic [CNT_W-1:0] wr_outstanding,
   output logic [CNT_W-1:0] rd_outstanding,
   output logic             trig_wr_timeout,
   output logic             trig_rd_timeout,
   output logic             trig_proto_err,
   output logic             trig_any,
   output logic [3:0]       err_code
);
   localparam logic [CNT_W-1:0]      CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0]      CNT_MAX  = '1;
   localparam logic [MON_IDLE_W-1:0] IDLE_ONE = MON_IDLE_W'(1);
   localparam logic [MON_IDLE_W-1:0] IDLE_MAX = '1;
   localparam logic [MON_IDLE_W-1:0] IDLE_TMO = MON_IDLE_W'(TIMEOUT_CYCLES);

   logic                  hs_aw, hs_w, hs_b, hs_ar, hs_r;
   logic                  err_b, err_r;
   logic [CNT_W-1:0]      wr_cnt_d, rd_cnt_d;
   logic [MON_IDLE_W-1:0] wr_idle_q, rd_idle_q, wr_idle_d, rd_idle_d;
   logic                  wr_fire, rd_fire;
   logic                  wr_to_d, rd_to_d, proto_d;
   logic [3:0]            err_d;

   assign hs_aw = mon_bus.awvalid & mon_bus.awready;
   assign hs_w  = mon_bus.wvalid  & mon_bus.wready;
   assign hs_b  = mon_bus.bvalid  & mon_bus.bready;
   assign hs_ar = mon_bus.arvalid & mon_bus.arready;
   assign hs_r  = mon_bus.rvalid  & mon_bus.rready;

   assign err_b = hs_b & (wr_outstanding == '0);
   assign err_r = hs_r & (rd_outstanding == '0);

   always_comb begin
      wr_cnt_d = wr_outstanding;
      rd_cnt_d = rd_outstanding;
      if (hs_aw && !hs_b && wr_outstanding != CNT_MAX)
         wr_cnt_d = wr_outstanding + CNT_ONE;
      else if (hs_b && !hs_aw && wr_outstanding != '0)
         wr_cnt_d = wr_outstanding - CNT_ONE;
      if (hs_ar && !(hs_r && mon_bus.rlast) && rd_outstanding != CNT_MAX)
         rd_cnt_d = rd_outstanding + CNT_ONE;
      else if (hs_r && mon_bus.rlast && !hs_ar && rd_outstanding != '0)
         rd_cnt_d = rd_outstanding - CNT_ONE;
   end

   assign wr_fire = (wr_idle_q == IDLE_TMO);
   assign rd_fire = (rd_idle_q == IDLE_TMO);

   // Restarting on fire re-arms the watchdog, so a cleared flag reasserts on a continuing stall.
   always_comb begin
      wr_idle_d = wr_idle_q;
      rd_idle_d = rd_idle_q;
      if (wr_outstanding == '0 || hs_aw || hs_w || hs_b || wr_fire)
         wr_idle_d = '0;
      else if (wr_idle_q != IDLE_MAX)
         wr_idle_d = wr_idle_q + IDLE_ONE;
      if (rd_outstanding == '0 || hs_ar || hs_r || rd_fire)
         rd_idle_d = '0;
      else if (rd_idle_q != IDLE_MAX)
         rd_idle_d = rd_idle_q + IDLE_ONE;
   end

   assign wr_to_d = wr_fire | (trig_wr_timeout & ~mon_clr);
   assign rd_to_d = rd_fire | (trig_rd_timeout & ~mon_clr);

`ifdef CL_AXI_MON_PROTO_CHK_EN
   localparam int                BEAT_W   = MON_LEN_W + 1;
   localparam logic [BEAT_W-1:0] BEAT_ONE = BEAT_W'(1);
   localparam logic [BEAT_W-1:0] BEAT_MAX = '1;

   logic                 fifo_push, fifo_pop, fifo_full, fifo_empty;
   logic [MON_LEN_W-1:0] fifo_head;
   logic [BEAT_W-1:0]    beat_q, beat_d, beat_tot, len_tot;
   logic [CNT_W-1:0]     w_ahead_q, w_ahead_d;
   logic                 err_early, err_late, err_ovf;
   mon_err_e             new_err;

   cl_axi_mon_len_fifo #(
      .DEPTH (LEN_FIFO_DEPTH),
      .W     (MON_LEN_W)
   ) u_len_fifo (
      .aclk  (aclk),
      .arst  (arst),
      .push  (fifo_push),
      .pop   (fifo_pop),
      .din   (mon_bus.awlen),
      .head  (fifo_head),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   assign beat_tot = (beat_q == BEAT_MAX) ? beat_q : beat_q + BEAT_ONE;
   assign len_tot  = {1'b0, fifo_head} + BEAT_ONE;

   always_comb begin
      fifo_push = 1'b0;
      fifo_pop  = 1'b0;
      beat_d    = beat_q;
      w_ahead_d = w_ahead_q;
      err_early = 1'b0;
      err_late  = 1'b0;
      err_ovf   = 1'b0;
      if (hs_w) begin
         if (mon_bus.wlast) begin
            beat_d = '0;
            if (!fifo_empty) begin
               fifo_pop  = 1'b1;
               err_early = (beat_tot < len_tot);
            end else if (w_ahead_q != CNT_MAX) begin
               w_ahead_d = w_ahead_q + CNT_ONE;
            end
         end else begin
            beat_d   = beat_tot;
            err_late = !fifo_empty && (beat_tot > len_tot);
         end
      end
      // An AW trailing its own W data only retires the early-data credit.
      if (hs_aw) begin
         if (w_ahead_q != '0) w_ahead_d = w_ahead_d - CNT_ONE;
         else if (fifo_full)  err_ovf   = 1'b1;
         else                 fifo_push = 1'b1;
      end
   end

   always_comb begin
      new_err = NONE;
      if      (err_b)     new_err = B_NO_OUTST;
      else if (err_r)     new_err = R_NO_OUTST;
      else if (err_early) new_err = WLAST_EARLY;
      else if (err_late)  new_err = WLAST_LATE;
      else if (err_ovf)   new_err = LEN_OVF;
   end

   always_comb begin
      err_d = err_code;
      if (new_err != NONE && (err_code == 4'd0 || mon_clr)) err_d = new_err;
      else if (mon_clr)                                     err_d = 4'd0;
   end

   assign proto_d = (new_err != NONE) | (trig_proto_err & ~mon_clr);

   always_ff @(posedge aclk or posedge arst) begin
      if (arst) begin
         beat_q    <= '0;
         w_ahead_q <= '0;
      end else begin
         beat_q    <= beat_d;
         w_ahead_q <= w_ahead_d;
      end
   end
`else
   logic unused_proto;
   assign unused_proto = ^{mon_bus.awlen, mon_bus.wlast, err_b, err_r, (LEN_FIFO_DEPTH == 0)};
   assign proto_d      = 1'b0;
   assign err_d        = 4'd0;
`endif

   always_ff @(posedge aclk or posedge arst) begin
      if (arst) begin
         wr_outstanding  <= '0;
         rd_outstanding  <= '0;
         wr_idle_q       <= '0;
         rd_idle_q       <= '0;
         trig_wr_timeout <= 1'b0;
         trig_rd_timeout <= 1'b0;
         trig_proto_err  <= 1'b0;
         trig_any        <= 1'b0;
         err_code        <= 4'd0;
      end else begin
         wr_outstanding  <= wr_cnt_d;
         rd_outstanding  <= rd_cnt_d;
         wr_idle_q       <= wr_idle_d;
         rd_idle_q       <= rd_idle_d;
         trig_wr_timeout <= wr_to_d;
         trig_rd_timeout <= rd_to_d;
         trig_proto_err  <= proto_d;
         trig_any        <= wr_to_d | rd_to_d | proto_d;
         err_code        <= err_d;
      end
   end

endmodule

// File: tb/tb_cl_axi_mon_trig.sv
// tb_cl_axi_mon_trig: directed stimulus, a per-cycle reference model and literal spot checks.
module tb_cl_axi_mon_trig;
   import cl_axi_mon_pkg::*;

   localparam int CNT_W = 8;
   localparam int TMO   = 16;
   localparam int DEPTH = 16;
   localparam int CMAX  = (1 << CNT_W) - 1;

   logic             aclk = 1'b0;
   logic             arst;
   logic             mon_clr;
   axi_bus_t         bus;
   logic [CNT_W-1:0] wr_outstanding, rd_outstanding;
   logic             trig_wr_timeout, trig_rd_timeout, trig_proto_err, trig_any;
   logic [3:0]       err_code;

   int errors = 0;
   int checks = 0;
   bit chk_en = 1'b0;

   always #5 aclk = ~aclk;

   cl_axi_mon_trig #(
      .CNT_W          (CNT_W),
      .TIMEOUT_CYCLES (TMO),
      .LEN_FIFO_DEPTH (DEPTH)
   ) dut (
      .aclk            (aclk),
      .arst            (arst),
      .mon_bus         (bus),
      .mon_clr         (mon_clr),
      .wr_outstanding  (wr_outstanding),
      .rd_outstanding  (rd_outstanding),
      .trig_wr_timeout (trig_wr_timeout),
      .trig_rd_timeout (trig_rd_timeout),
      .trig_proto_err  (trig_proto_err),
      .trig_any        (trig_any),
      .err_code        (err_code)
   );

   task automatic check(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Reference model: counts as plain integers, watchdog as cycles since the last restart point.
   int m_wr = 0, m_rd = 0, m_code = 0;
   bit m_wto = 0, m_rto = 0, m_perr = 0;
   int n = 0, wr_ref = 0, rd_ref = 0;
   int lenq[$];
   int m_beats = 0, m_ahead = 0;

   always @(posedge aclk or posedge arst) begin
      if (arst) begin
         m_wr = 0; m_rd = 0; m_code = 0;
         m_wto = 0; m_rto = 0; m_perr = 0;
         n = 0; wr_ref = 0; rd_ref = 0;
         lenq.delete(); m_beats = 0; m_ahead = 0;
      end else begin
         automatic bit aw = bus.awvalid && bus.awready;
         automatic bit w  = bus.wvalid  && bus.wready;
         automatic bit b  = bus.bvalid  && bus.bready;
         automatic bit ar = bus.arvalid && bus.arready;
         automatic bit r  = bus.rvalid  && bus.rready;
         automatic int code = 0;
         automatic bit wfire, rfire;
         automatic int qsz = lenq.size();
         automatic int ahead0 = m_ahead;
         n++;
         wfire = (n - wr_ref == TMO + 1);
         rfire = (n - rd_ref == TMO + 1);
         if (m_wr == 0 || aw || w || b || wfire) wr_ref = n;
         if (m_rd == 0 || ar || r || rfire) rd_ref = n;
         if (b && m_wr == 0) code = 1;
         else if (r && m_rd == 0) code = 2;
`ifdef CL_AXI_MON_PROTO_CHK_EN
         if (w) begin
            m_beats++;
            if (bus.wlast) begin
               if (qsz > 0) begin
                  if (m_beats < lenq.pop_front() + 1 && code == 0) code = 3;
               end else begin
                  m_ahead++;
               end
               m_beats = 0;
            end else if (qsz > 0 && m_beats > lenq[0] + 1 && code == 0) begin
               code = 4;
            end
         end
         if (aw) begin
            if (ahead0 > 0) m_ahead--;
            else if (qsz >= DEPTH) begin if (code == 0) code = 5; end
            else lenq.push_back(int'(bus.awlen));
         end
         m_perr = (code != 0) || (m_perr && !mon_clr);
         if (code != 0 && (m_code == 0 || mon_clr)) m_code = code;
         else if (mon_clr) m_code = 0;
`endif
         if (aw && !b) m_wr = (m_wr < CMAX) ? m_wr + 1 : CMAX;
         else if (b && !aw) m_wr = (m_wr > 0) ? m_wr - 1 : 0;
         if (ar && !(r && bus.rlast)) m_rd = (m_rd < CMAX) ? m_rd + 1 : CMAX;
         else if (r && bus.rlast && !ar) m_rd = (m_rd > 0) ? m_rd - 1 : 0;
         m_wto = wfire || (m_wto && !mon_clr);
         m_rto = rfire || (m_rto && !mon_clr);
      end
   end

   always @(negedge aclk) begin
      if (chk_en) begin
         check("wr_outstanding", int'(wr_outstanding), m_wr);
         check("rd_outstanding", int'(rd_outstanding), m_rd);
         check("trig_wr_timeout", int'(trig_wr_timeout), int'(m_wto));
         check("trig_rd_timeout", int'(trig_rd_timeout), int'(m_rto));
         check("trig_proto_err", int'(trig_proto_err), int'(m_perr));
         check("trig_any", int'(trig_any), int'(m_wto || m_rto || m_perr));
         check("err_code", int'(err_code), m_code);
      end
   end

   task automatic drive(input bit aw, w, wl, b, ar, r, rl, input int len, input bit clr);
      bus         = '0;
      bus.awvalid = aw;
      bus.awready = aw;
      bus.awlen   = 8'(len);
      bus.wvalid  = w;
      bus.wready  = 1'b1;
      bus.wlast   = wl;
      bus.bvalid  = b;
      bus.bready  = 1'b1;
      bus.arvalid = 1'b1;
      bus.arready = ar;
      bus.rvalid  = r;
      bus.rready  = 1'b1;
      bus.rlast   = rl;
      mon_clr     = clr;
      @(posedge aclk);
      #1;
   endtask

   task automatic idle(input int k);
      repeat (k) drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic pin_all_zero(input string tag);
      check({tag, "_wr"}, int'(wr_outstanding), 0);
      check({tag, "_rd"}, int'(rd_outstanding), 0);
      check({tag, "_wto"}, int'(trig_wr_timeout), 0);
      check({tag, "_rto"}, int'(trig_rd_timeout), 0);
      check({tag, "_perr"}, int'(trig_proto_err), 0);
      check({tag, "_any"}, int'(trig_any), 0);
      check({tag, "_code"}, int'(err_code), 0);
   endtask

   initial begin
      bus = '0; mon_clr = 1'b0; arst = 1'b0;
      #2 arst = 1'b1; chk_en = 1'b1;
      repeat (3) @(posedge aclk);
      #1;
      pin_all_zero("reset");
      arst = 1'b0;

      // Well-formed burst: AW len 3, four beats, B.
      drive(1, 0, 0, 0, 0, 0, 0, 3, 0);
      check("t1_wr_after_aw", int'(wr_outstanding), 1);
      repeat (3) drive(0, 1, 0, 0, 0, 0, 0, 0, 0);
      drive(0, 1, 1, 0, 0, 0, 0, 0, 0);
      drive(0, 0, 0, 1, 0, 0, 0, 0, 0);
      check("t1_wr_after_b", int'(wr_outstanding), 0);
      check("t1_perr", int'(trig_proto_err), 0);

      // Short burst, then a stray B.
      drive(1, 0, 0, 0, 0, 0, 0, 3, 0);
      drive(0, 1, 0, 0, 0, 0, 0, 0, 0);
      drive(0, 1, 0, 0, 0, 0, 0, 0, 0);
      drive(0, 1, 1, 0, 0, 0, 0, 0, 0);
`ifdef CL_AXI_MON_PROTO_CHK_EN
      check("t2_perr", int'(trig_proto_err), 1);
      check("t2_code_early", int'(err_code), 3);
      check("t2_any", int'(trig_any), 1);
`endif
      drive(0, 0, 0, 1, 0, 0, 0, 0, 0);
      drive(0, 0, 0, 1, 0, 0, 0, 0, 0);
      check("t2_wr_floor", int'(wr_outstanding), 0);
`ifdef CL_AXI_MON_PROTO_CHK_EN
      check("t2_code_held", int'(err_code), 3);
`endif
      drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
      check("t2_clr_perr", int'(trig_proto_err), 0);
      check("t2_clr_code", int'(err_code), 0);

      // Unanswered AR: flag 17 cycles after the handshake, cleared, back 16 cycles after the clear.
      drive(0, 0, 0, 0, 1, 0, 0, 0, 0);
      check("t3_rd", int'(rd_outstanding), 1);
      idle(TMO);
      check("t3_rto_not_yet", int'(trig_rd_timeout), 0);
      idle(1);
      check("t3_rto_set", int'(trig_rd_timeout), 1);
      check("t3_any", int'(trig_any), 1);
      drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
      check("t3_rto_cleared", int'(trig_rd_timeout), 0);
      idle(TMO - 1);
      check("t3_rto_still_low", int'(trig_rd_timeout), 0);
      idle(1);
      check("t3_rto_reassert", int'(trig_rd_timeout), 1);
      drive(0, 0, 0, 0, 0, 1, 1, 0, 0);
      check("t3_rd_closed", int'(rd_outstanding), 0);
      drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
      check("t3_rto_final", int'(trig_rd_timeout), 0);

      // Simultaneous AW/B at 2 outstanding; R with nothing outstanding.
      drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
      drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
      drive(1, 0, 0, 1, 0, 0, 0, 0, 0);
      check("t4_wr_same", int'(wr_outstanding), 2);
      drive(0, 0, 0, 0, 0, 1, 1, 0, 0);
      check("t4_rd_floor", int'(rd_outstanding), 0);
`ifdef CL_AXI_MON_PROTO_CHK_EN
      check("t4_code_r", int'(err_code), 2);
`endif
      drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
      repeat (3) drive(0, 1, 1, 0, 0, 0, 0, 0, 0);
      drive(0, 0, 0, 1, 0, 0, 0, 0, 0);
      drive(0, 0, 0, 1, 0, 0, 0, 0, 0);
      check("t4_wr_drained", int'(wr_outstanding), 0);

      // W data ahead of its AW, then FIFO overflow.
      drive(0, 1, 0, 0, 0, 0, 0, 0, 0);
      drive(0, 1, 1, 0, 0, 0, 0, 0, 0);
      drive(1, 0, 0, 0, 0, 0, 0, 1, 0);
      check("t5_wr", int'(wr_outstanding), 1);
`ifdef CL_AXI_MON_PROTO_CHK_EN
      check("t5_code_none", int'(err_code), 0);
`endif
      drive(0, 0, 0, 1, 0, 0, 0, 0, 0);
      repeat (DEPTH + 1) drive(1, 0, 0, 0, 0, 0, 0, 2, 0);
      check("t5_wr17", int'(wr_outstanding), DEPTH + 1);
`ifdef CL_AXI_MON_PROTO_CHK_EN
      check("t5_code_ovf", int'(err_code), 5);
`endif
      idle(TMO);
      check("t5_wto_not_yet", int'(trig_wr_timeout), 0);
      idle(1);
      check("t5_wto_set", int'(trig_wr_timeout), 1);
      check("t5_any", int'(trig_any), 1);

      // Mid-stream reset, then a clear colliding with new events.
      arst = 1'b1;
      #1;
      pin_all_zero("arst");
      repeat (2) @(posedge aclk);
      #1 arst = 1'b0;
      drive(0, 0, 0, 0, 1, 0, 0, 0, 0);
      idle(TMO);
      drive(0, 0, 0, 1, 0, 0, 0, 0, 1);
      check("t6_rto_set_wins", int'(trig_rd_timeout), 1);
      check("t6_any", int'(trig_any), 1);
`ifdef CL_AXI_MON_PROTO_CHK_EN
      check("t6_perr_set_wins", int'(trig_proto_err), 1);
      check("t6_code_b", int'(err_code), 1);
`endif

      // Write counter saturation.
      repeat (CMAX + 5) drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
      check("t7_wr_sat", int'(wr_outstanding), CMAX);
      idle(2);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
